// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl.sv
// Purpose: sleep/wake sequencer plus ICG-style latch producing a glitch-free gated clock GCLK from CLK.
// Latency: SLEEP_ACK rises DRAIN_CYC+1 CLK rises after SLEEP_REQ (BUSY low); falls WAKE_CYC+1 rises after SLEEP_REQ drops.
// Backpressure: BUSY high holds the drain counter at zero, so gating waits until the block is idle.
// Optional: define GF180MCU_FD_SC_MCU9T5V0_CLKGATE_TE_EN to let TE force the latch open (scan clocking).
`timescale 1ns/1ps

module gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl #(
  parameter int DRAIN_CYC = 4,
  parameter int WAKE_CYC  = 2,
  parameter int CW        = 8
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       SLEEP_REQ,
  input  logic       BUSY,
  input  logic       TE,
  output logic       GCLK,
  output logic       EN_Q,
  output logic       SLEEP_ACK,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_GATED = 2'b10,
    ST_WAKE  = 2'b11
  } state_t;

  // Terminal counts; the counter stops at these values, it never wraps.
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_CYC - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_en_q;
  logic            r_ack;
  logic            r_latch_q;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_en_nxt;
  logic            w_ack_nxt;
  logic            w_latch_d;

  // State, counter, enable and acknowledge registers; reset lands in RUN with the clock enabled.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_en_q  <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en_q  <= w_en_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next-state logic. In DRAIN an abort (SLEEP_REQ low) beats both BUSY and drain completion,
  // and BUSY beats completion, so a late BUSY rise always cancels gating.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en_q;
    w_ack_nxt   = r_ack;
    case (r_state)
      ST_RUN: begin
        w_en_nxt  = 1'b1;
        w_ack_nxt = 1'b0;
        w_cnt_nxt = '0;
        if (SLEEP_REQ) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_en_nxt  = 1'b1;
        w_ack_nxt = 1'b0;
        if (!SLEEP_REQ) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (BUSY) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= DRAIN_LAST) begin
          w_state_nxt = ST_GATED;
          w_cnt_nxt   = '0;
          w_en_nxt    = 1'b0;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GATED: begin
        // BUSY is deliberately ignored here; only the request level matters.
        w_cnt_nxt = '0;
        w_en_nxt  = 1'b0;
        w_ack_nxt = 1'b1;
        if (!SLEEP_REQ) begin
          w_state_nxt = ST_WAKE;
          w_en_nxt    = 1'b1;
        end
      end
      ST_WAKE: begin
        // A new SLEEP_REQ is not looked at until RUN is reached.
        w_en_nxt  = 1'b1;
        w_ack_nxt = 1'b1;
        if (r_cnt >= WAKE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
        w_en_nxt    = 1'b1;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKGATE_TE_EN
  // Test enable opens the gate regardless of the FSM; the handshake keeps running underneath.
  always_comb begin
    w_latch_d = r_en_q | TE;
  end
`else
  logic w_te_unused;
  assign w_te_unused = TE;

  // Without test support the gate follows the registered enable alone.
  always_comb begin
    w_latch_d = r_en_q;
  end
`endif

  // Enable latch: transparent while CLK is low, frozen while high, so GCLK pulses are never cut short.
  // Reset forces it open so the downstream domain is clocked during reset.
  always_latch begin
    if (!RN) begin
      r_latch_q <= 1'b1;
    end else if (!CLK) begin
      r_latch_q <= w_latch_d;
    end
  end

  assign GCLK      = CLK & r_latch_q;
  assign EN_Q      = r_en_q;
  assign SLEEP_ACK = r_ack;
  assign STATE     = r_state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl.sv
// Purpose: directed self-checking bench for the clock-gate controller (DRAIN_CYC=4, WAKE_CYC=2).
// Latency: samples 2 ns after each CLK rise (high phase), so GCLK there shows whether that pulse passed.
// Backpressure: BUSY stalls of the drain phase are exercised explicitly.
`timescale 1ns/1ps

module tb_gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl;

  logic       CLK;
  logic       RN;
  logic       SLEEP_REQ;
  logic       BUSY;
  logic       TE;
  logic       GCLK;
  logic       EN_Q;
  logic       SLEEP_ACK;
  logic [1:0] STATE;

  int n_checks;
  int n_fail;
  int gclk_pulses;
  int runt_cnt;
  int p0;
  time t_g_rise;
  bit  g_seen;

  gf180mcu_fd_sc_mcu9t5v0__clkgate_ctrl #(
    .DRAIN_CYC(4),
    .WAKE_CYC (2),
    .CW       (8)
  ) dut (
    .CLK      (CLK),
    .RN       (RN),
    .SLEEP_REQ(SLEEP_REQ),
    .BUSY     (BUSY),
    .TE       (TE),
    .GCLK     (GCLK),
    .EN_Q     (EN_Q),
    .SLEEP_ACK(SLEEP_ACK),
    .STATE    (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every GCLK pulse must rise with CLK high and last a full 5 ns high phase.
  always @(posedge GCLK) begin
    gclk_pulses++;
    t_g_rise = $time;
    g_seen   = 1'b1;
    if (CLK !== 1'b1) runt_cnt++;
  end

  always @(negedge GCLK) begin
    if (g_seen && (($time - t_g_rise) != 5)) runt_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic en,
                         input logic ack, input logic gclk);
    chk({tag, "_state"}, 32'(STATE), 32'(st));
    chk({tag, "_en"},    32'(EN_Q),  32'(en));
    chk({tag, "_ack"},   32'(SLEEP_ACK), 32'(ack));
    chk({tag, "_gclk"},  32'(GCLK),  32'(gclk));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic te_gclk;
`ifdef GF180MCU_FD_SC_MCU9T5V0_CLKGATE_TE_EN
    te_gclk = 1'b1;
`else
    te_gclk = 1'b0;
`endif
    n_checks = 0; n_fail = 0; gclk_pulses = 0; runt_cnt = 0; g_seen = 1'b0; t_g_rise = 0;
    RN = 1'b0; SLEEP_REQ = 1'b0; BUSY = 1'b0; TE = 1'b0;

    // Reset held 3 cycles: RUN, enabled, clock passes.
    repeat (3) tick();
    chk_all("rst", 2'b00, 1'b1, 1'b0, 1'b1);
    @(negedge CLK); #2;
    chk("rst_gclk_lo", 32'(GCLK), 32'd0);
    RN = 1'b1;
    tick();
    chk_all("rel", 2'b00, 1'b1, 1'b0, 1'b1);

    // Basic sleep: ACK after the 5th rise; the 5th pulse still passes in full.
    SLEEP_REQ = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) chk_all($sformatf("sleep%0d", k), 2'b01, 1'b1, 1'b0, 1'b1);
      else       chk_all("sleep5", 2'b10, 1'b0, 1'b1, 1'b1);
    end
    p0 = gclk_pulses;
    repeat (3) tick();
    chk_all("gated", 2'b10, 1'b0, 1'b1, 1'b0);
    chk("gated_pulses", 32'(gclk_pulses - p0), 32'd0);

    // Test enable while gated.
    TE = 1'b1;
    tick();
    chk_all("te_on", 2'b10, 1'b0, 1'b1, te_gclk);
    tick();
    chk("te_on2_gclk", 32'(GCLK), 32'(te_gclk));
    TE = 1'b0;
    tick();
    chk_all("te_off", 2'b10, 1'b0, 1'b1, 1'b0);

    // Wake: EN_Q up next rise, two full pulses, ACK drops with the return to RUN.
    p0 = gclk_pulses;
    SLEEP_REQ = 1'b0;
    tick(); chk_all("wakeA", 2'b11, 1'b1, 1'b1, 1'b0);
    tick(); chk_all("wakeB", 2'b11, 1'b1, 1'b1, 1'b1);
    tick(); chk_all("wakeC", 2'b00, 1'b1, 1'b0, 1'b1);
    chk("wake_pulses", 32'(gclk_pulses - p0), 32'd2);

    // BUSY stall on drain rises 2..6: gating 4 rises after BUSY drops.
    SLEEP_REQ = 1'b1;
    tick(); chk("busy_e1_state", 32'(STATE), 32'd1);
    BUSY = 1'b1;
    repeat (5) tick();
    chk_all("busy_e6", 2'b01, 1'b1, 1'b0, 1'b1);
    BUSY = 1'b0;
    repeat (3) tick();
    chk_all("busy_e9", 2'b01, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("busy_e10", 2'b10, 1'b0, 1'b1, 1'b1);
    SLEEP_REQ = 1'b0;
    repeat (3) tick();
    chk("busy_woke_state", 32'(STATE), 32'd0);

    // Abort at count 2: back to RUN, never gated.
    p0 = gclk_pulses;
    SLEEP_REQ = 1'b1;
    repeat (3) tick();
    chk("abort_e3_state", 32'(STATE), 32'd1);
    SLEEP_REQ = 1'b0;
    tick();
    chk_all("abort_e4", 2'b00, 1'b1, 1'b0, 1'b1);
    tick();
    chk("abort_pulses", 32'(gclk_pulses - p0), 32'd5);

    // Abort on the completing drain cycle: abort wins.
    SLEEP_REQ = 1'b1;
    repeat (4) tick();
    chk("late_abort_e4_state", 32'(STATE), 32'd1);
    SLEEP_REQ = 1'b0;
    tick();
    chk_all("late_abort_e5", 2'b00, 1'b1, 1'b0, 1'b1);

    // BUSY rising on the completing drain cycle cancels gating and restarts the count.
    SLEEP_REQ = 1'b1;
    repeat (4) tick();
    BUSY = 1'b1;
    tick();
    chk_all("late_busy_e5", 2'b01, 1'b1, 1'b0, 1'b1);
    BUSY = 1'b0;
    repeat (3) tick();
    chk("late_busy_e8_ack", 32'(SLEEP_ACK), 32'd0);
    tick();
    chk_all("late_busy_e9", 2'b10, 1'b0, 1'b1, 1'b1);
    tick();
    chk("late_busy_gated_gclk", 32'(GCLK), 32'd0);

    // Reset while gated: immediate RUN, clock back on the next high phase.
    @(negedge CLK); #1;
    RN = 1'b0;
    SLEEP_REQ = 1'b0;
    #1;
    chk_all("mid_rst", 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mid_rst_gclk", 32'(GCLK), 32'd1);
    @(negedge CLK); #2;
    RN = 1'b1;
    tick();
    chk_all("mid_rel", 2'b00, 1'b1, 1'b0, 1'b1);

    chk("runt_pulses", 32'(runt_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
